// File: rtl/kv_cache_mh.sv
// Multi-head KV cache: token appends (valid/ready) and per-head streaming
// scans, oldest to newest. An optional ring mode overwrites the oldest token
// when the cache is full.
module kv_cache_mh #(
  parameter int MAX_SEQ_LEN = 8,
  parameter int HEAD_DIM    = 4,
  parameter int DW          = 4,
  parameter int NUM_HEADS   = 2,
  parameter int WINDOW_MODE = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          clear,
  input  logic                                          append_valid,
  output logic                                          append_ready,
  input  logic [NUM_HEADS*HEAD_DIM*DW-1:0]              append_k,
  input  logic [NUM_HEADS*HEAD_DIM*DW-1:0]              append_v,
  input  logic                                          scan_start,
  input  logic [((NUM_HEADS>1)?$clog2(NUM_HEADS):1)-1:0] scan_head,
  output logic                                          scan_busy,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [HEAD_DIM*DW-1:0]                        out_k,
  output logic [HEAD_DIM*DW-1:0]                        out_v,
  output logic [$clog2(MAX_SEQ_LEN)-1:0]                out_pos,
  output logic                                          out_last,
  output logic [$clog2(MAX_SEQ_LEN):0]                  seq_len,
  output logic                                          full,
  output logic                                          overflow_err
);

  localparam int AW = $clog2(MAX_SEQ_LEN);
  localparam int HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  localparam int VW = HEAD_DIM * DW;

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t          state;
  logic [VW-1:0]   mem_k [MAX_SEQ_LEN][NUM_HEADS];
  logic [VW-1:0]   mem_v [MAX_SEQ_LEN][NUM_HEADS];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   oldest;
  logic [AW-1:0]   base;
  logic [AW-1:0]   next_slot;
  logic [HW-1:0]   head_r;
  logic [AW:0]     len_r;
  logic            accept;

  assign full         = (seq_len == (AW+1)'(MAX_SEQ_LEN));
  assign append_ready = (state == IDLE) && !clear && !(full && (WINDOW_MODE == 0));
  assign accept       = append_valid && append_ready;
  assign scan_busy    = (state == STREAM);
  assign out_last     = out_valid && ({1'b0, out_pos} == (len_r - (AW+1)'(1)));
  // base is the oldest slot latched at scan start, so ring wrap falls out of AW-bit arithmetic
  assign next_slot    = base + out_pos + AW'(1);

  // Storage: all heads of an accepted token land in slot wr_ptr
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned h = 0; h < NUM_HEADS; h++) begin
        mem_k[wr_ptr][h] <= append_k[h*VW +: VW];
        mem_v[wr_ptr][h] <= append_v[h*VW +: VW];
      end
    end
  end

  // Pointers, occupancy, error flag and the scan FSM with its output register
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      oldest       <= '0;
      base         <= '0;
      seq_len      <= '0;
      head_r       <= '0;
      len_r        <= '0;
      out_valid    <= 1'b0;
      out_pos      <= '0;
      out_k        <= '0;
      out_v        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (!full) seq_len <= seq_len + (AW+1)'(1);
        else       oldest  <= oldest + AW'(1);
      end
      if (append_valid && full && (WINDOW_MODE == 0)) overflow_err <= 1'b1;

      case (state)
        IDLE: begin
          // Reads the pre-append oldest slot: a same-cycle append is excluded
          if (scan_start && (seq_len != '0)) begin
            state     <= STREAM;
            head_r    <= scan_head;
            len_r     <= seq_len;
            base      <= oldest;
            out_k     <= mem_k[oldest][scan_head];
            out_v     <= mem_v[oldest][scan_head];
            out_pos   <= '0;
            out_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              out_pos <= out_pos + AW'(1);
              out_k   <= mem_k[next_slot][head_r];
              out_v   <= mem_v[next_slot][head_r];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
